// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control sequencer: state encodings, opcodes,
// write-back select codes and the decoded strobe bundle.
package cpu_ctrl_pkg;

  localparam logic [4:0] ST_IDLE   = 5'b11111;
  localparam logic [4:0] ST_FETCH  = 5'b10000;
  localparam logic [4:0] ST_DECODE = 5'b00000;
  localparam logic [4:0] ST_LOAD   = 5'b00001;
  localparam logic [4:0] ST_MOV    = 5'b00010;
  localparam logic [4:0] ST_ALU1   = 5'b00011;
  localparam logic [4:0] ST_ALU2   = 5'b00100;
  localparam logic [4:0] ST_ALU3   = 5'b00101;
  localparam logic [4:0] ST_BRANCH = 5'b00110;

  localparam logic [3:0] OP_LOAD = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_BR   = 4'b0110;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_RS  = 2'b10;

  typedef struct packed {
    logic       mem_rd;
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic       a_ld;
    logic       b_ld;
    logic       rf_we;
    logic       retire;
    logic       busy;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_dec.sv
// Combinational Moore decode of the control state into datapath strobes;
// only the FETCH and BRANCH strobes look at the live mem_ready / flag_z.
module cpu_ctrl_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] state,
  input  logic       mem_ready,
  input  logic       flag_z,
  input  logic [2:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl      = '0;
    ctrl.busy = (state != ST_IDLE);
    case (state)
      ST_FETCH: begin
        ctrl.mem_rd = 1'b1;
        ctrl.ir_ld  = mem_ready;
        ctrl.pc_inc = mem_ready;
      end
      ST_LOAD: begin
        ctrl.rf_we  = 1'b1;
        ctrl.wb_sel = WB_IMM;
        ctrl.retire = 1'b1;
      end
      ST_MOV: begin
        ctrl.rf_we  = 1'b1;
        ctrl.wb_sel = WB_RS;
        ctrl.retire = 1'b1;
      end
      ST_ALU1: ctrl.a_ld = 1'b1;
      ST_ALU2: ctrl.b_ld = 1'b1;
      ST_ALU3: begin
        ctrl.rf_we  = 1'b1;
        ctrl.wb_sel = WB_ALU;
        ctrl.alu_op = op;
        ctrl.retire = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.pc_ld  = flag_z;
        ctrl.retire = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer top: state register, instruction register and optional
// saturating perf counters (compiled in with CPU_CTRL_PERF_CNT_EN).
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int IW    = 8,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    next_state,
  input  logic [IW-1:0] instr,
  input  logic          mem_ready,
  input  logic          flag_z,
  output logic [4:0]    state,
  output logic [3:0]    code,
  output logic [1:0]    rd,
  output logic [1:0]    rs,
  output logic          mem_rd,
  output logic          ir_ld,
  output logic          pc_inc,
  output logic          pc_ld,
  output logic          a_ld,
  output logic          b_ld,
  output logic          rf_we,
  output logic          retire,
  output logic          busy,
  output logic [1:0]    wb_sel,
  output logic [2:0]    alu_op
`ifdef CPU_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  logic [IW-1:0] ir;
  ctrl_t         ctrl;
  logic          fetch_stall;

  assign fetch_stall = (state == ST_FETCH) && !mem_ready;

  // Reset takes priority over both the stall hold and the IR load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      if (!fetch_stall) state <= next_state;
      if (state == ST_FETCH && mem_ready) ir <= instr;
    end
  end

  assign code = ir[7:4];
  assign rd   = ir[3:2];
  assign rs   = ir[1:0];

  cpu_ctrl_dec u_dec (
    .state     (state),
    .mem_ready (mem_ready),
    .flag_z    (flag_z),
    .op        (ir[6:4]),
    .ctrl      (ctrl)
  );

  assign mem_rd = ctrl.mem_rd;
  assign ir_ld  = ctrl.ir_ld;
  assign pc_inc = ctrl.pc_inc;
  assign pc_ld  = ctrl.pc_ld;
  assign a_ld   = ctrl.a_ld;
  assign b_ld   = ctrl.b_ld;
  assign rf_we  = ctrl.rf_we;
  assign retire = ctrl.retire;
  assign busy   = ctrl.busy;
  assign wb_sel = ctrl.wb_sel;
  assign alu_op = ctrl.alu_op;

`ifdef CPU_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (retire && instr_cnt != '1) instr_cnt <= instr_cnt + 1'b1;
      if (busy && cycle_cnt != '1)   cycle_cnt <= cycle_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: directed cycle table, optional counter saturation
// sequence, then randomized cycles against an abstract reference model.
module tb_cpu_ctrl_seq;
  import cpu_ctrl_pkg::*;

  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] next_state;
  logic [7:0] instr;
  logic       mem_ready, flag_z;
  logic [4:0] state;
  logic [3:0] code;
  logic [1:0] rd, rs, wb_sel;
  logic       mem_rd, ir_ld, pc_inc, pc_ld, a_ld, b_ld, rf_we, retire, busy;
  logic [2:0] alu_op;
`ifdef CPU_CTRL_PERF_CNT_EN
  logic [CW-1:0] instr_cnt, cycle_cnt;
`endif

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.IW(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .next_state(next_state), .instr(instr),
    .mem_ready(mem_ready), .flag_z(flag_z), .state(state), .code(code),
    .rd(rd), .rs(rs), .mem_rd(mem_rd), .ir_ld(ir_ld), .pc_inc(pc_inc),
    .pc_ld(pc_ld), .a_ld(a_ld), .b_ld(b_ld), .rf_we(rf_we), .retire(retire),
    .busy(busy), .wb_sel(wb_sel), .alu_op(alu_op)
`ifdef CPU_CTRL_PERF_CNT_EN
    , .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
`endif
  );

  // Strobe vector: {mem_rd,ir_ld,pc_inc,pc_ld,a_ld,b_ld,rf_we,retire,busy,wb_sel,alu_op}
  localparam logic [13:0] MRD = 14'h2000, IRL = 14'h1000, PCI = 14'h0800,
                          PCL = 14'h0400, AL  = 14'h0200, BL  = 14'h0100,
                          WE  = 14'h0080, RET = 14'h0040, BSY = 14'h0020,
                          WBR = 14'h0010, WBI = 14'h0008;

  logic [13:0] strb;
  assign strb = {mem_rd, ir_ld, pc_inc, pc_ld, a_ld, b_ld, rf_we, retire, busy, wb_sel, alu_op};

  typedef struct {
    logic        rst;
    logic [4:0]  ns;
    logic [7:0]  instr;
    logic        mr;
    logic        fz;
    logic [4:0]  st;
    logic [7:0]  ir;
    logic [13:0] strb;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0, n_pass = 0;

  function automatic vec_t v(logic r, logic [4:0] ns, logic [7:0] in, logic mr, logic fz,
                             logic [4:0] st, logic [7:0] ir, logic [13:0] s);
    vec_t x;
    x.rst = r; x.ns = ns; x.instr = in; x.mr = mr; x.fz = fz;
    x.st = st; x.ir = ir; x.strb = s;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic [4:0] ns, input logic [7:0] in,
                       input logic mr, input logic fz);
    rst = r; next_state = ns; instr = in; mem_ready = mr; flag_z = fz;
  endtask

  // Reference model: expected strobes per state from a lookup table.
  logic [13:0] base[32];
  logic [4:0]  m_state;
  logic [7:0]  m_ir;
  logic [CW-1:0] m_icnt, m_ccnt;

  function automatic logic [13:0] expect_strb(logic [4:0] s, logic [7:0] irv, logic mr, logic fz);
    logic [13:0] e;
    e = base[s];
    if (s == ST_FETCH && mr) e = e | IRL | PCI;
    if (s == ST_BRANCH && fz) e = e | PCL;
    if (s == ST_ALU3) e = e | {11'd0, irv[6:4]};
    return e;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) base[i] = BSY;
    base[ST_IDLE]   = '0;
    base[ST_FETCH]  = MRD | BSY;
    base[ST_DECODE] = BSY;
    base[ST_LOAD]   = WE | RET | BSY | WBI;
    base[ST_MOV]    = WE | RET | BSY | WBR;
    base[ST_ALU1]   = AL | BSY;
    base[ST_ALU2]   = BL | BSY;
    base[ST_ALU3]   = WE | RET | BSY;
    base[ST_BRANCH] = RET | BSY;

    // Each row: inputs for this cycle and outputs expected before its edge.
    vecs.push_back(v(1, ST_FETCH,  8'h00, 0, 0, ST_IDLE,   8'h00, '0));
    vecs.push_back(v(1, ST_FETCH,  8'h00, 0, 0, ST_IDLE,   8'h00, '0));
    vecs.push_back(v(0, ST_FETCH,  8'h00, 0, 0, ST_IDLE,   8'h00, '0));
    vecs.push_back(v(0, ST_DECODE, 8'hAA, 0, 0, ST_FETCH,  8'h00, MRD | BSY));
    vecs.push_back(v(0, ST_DECODE, 8'hAA, 0, 0, ST_FETCH,  8'h00, MRD | BSY));
    vecs.push_back(v(0, ST_DECODE, 8'hAA, 0, 0, ST_FETCH,  8'h00, MRD | BSY));
    vecs.push_back(v(0, ST_DECODE, 8'h2B, 1, 0, ST_FETCH,  8'h00, MRD | IRL | PCI | BSY));
    vecs.push_back(v(0, ST_ALU1,   8'h00, 1, 0, ST_DECODE, 8'h2B, BSY));
    vecs.push_back(v(0, ST_ALU2,   8'h00, 0, 0, ST_ALU1,   8'h2B, AL | BSY));
    vecs.push_back(v(0, ST_ALU3,   8'h00, 0, 0, ST_ALU2,   8'h2B, BL | BSY));
    vecs.push_back(v(0, ST_FETCH,  8'h00, 0, 0, ST_ALU3,   8'h2B, WE | RET | BSY | 14'd2));
    vecs.push_back(v(0, ST_DECODE, 8'h3B, 1, 0, ST_FETCH,  8'h2B, MRD | IRL | PCI | BSY));
    vecs.push_back(v(0, ST_ALU1,   8'h00, 0, 0, ST_DECODE, 8'h3B, BSY));
    vecs.push_back(v(0, ST_ALU2,   8'h00, 0, 0, ST_ALU1,   8'h3B, AL | BSY));
    vecs.push_back(v(0, ST_ALU3,   8'h00, 0, 0, ST_ALU2,   8'h3B, BL | BSY));
    vecs.push_back(v(0, ST_FETCH,  8'h00, 0, 0, ST_ALU3,   8'h3B, WE | RET | BSY | 14'd3));
    vecs.push_back(v(0, ST_DECODE, 8'h61, 1, 0, ST_FETCH,  8'h3B, MRD | IRL | PCI | BSY));
    vecs.push_back(v(0, ST_BRANCH, 8'h00, 0, 0, ST_DECODE, 8'h61, BSY));
    vecs.push_back(v(0, ST_FETCH,  8'h00, 0, 1, ST_BRANCH, 8'h61, PCL | RET | BSY));
    vecs.push_back(v(0, ST_DECODE, 8'h62, 1, 1, ST_FETCH,  8'h61, MRD | IRL | PCI | BSY));
    vecs.push_back(v(0, ST_BRANCH, 8'h00, 0, 1, ST_DECODE, 8'h62, BSY));
    vecs.push_back(v(0, ST_FETCH,  8'h00, 0, 0, ST_BRANCH, 8'h62, RET | BSY));
    vecs.push_back(v(0, ST_DECODE, 8'h05, 1, 0, ST_FETCH,  8'h62, MRD | IRL | PCI | BSY));
    vecs.push_back(v(0, ST_LOAD,   8'h00, 1, 0, ST_DECODE, 8'h05, BSY));
    vecs.push_back(v(0, ST_FETCH,  8'hFF, 1, 0, ST_LOAD,   8'h05, WE | RET | BSY | WBI));
    vecs.push_back(v(0, ST_DECODE, 8'h1A, 1, 0, ST_FETCH,  8'h05, MRD | IRL | PCI | BSY));
    vecs.push_back(v(0, ST_MOV,    8'h00, 0, 0, ST_DECODE, 8'h1A, BSY));
    vecs.push_back(v(0, ST_FETCH,  8'h00, 0, 0, ST_MOV,    8'h1A, WE | RET | BSY | WBR));
    vecs.push_back(v(0, ST_DECODE, 8'h3C, 1, 0, ST_FETCH,  8'h1A, MRD | IRL | PCI | BSY));
    vecs.push_back(v(0, ST_ALU1,   8'h00, 0, 0, ST_DECODE, 8'h3C, BSY));
    vecs.push_back(v(0, ST_ALU2,   8'h00, 0, 0, ST_ALU1,   8'h3C, AL | BSY));
    vecs.push_back(v(1, ST_ALU3,   8'h00, 0, 0, ST_ALU2,   8'h3C, BL | BSY));
    vecs.push_back(v(0, ST_FETCH,  8'h00, 0, 0, ST_IDLE,   8'h00, '0));
    vecs.push_back(v(1, ST_DECODE, 8'h55, 1, 0, ST_FETCH,  8'h00, MRD | IRL | PCI | BSY));
    vecs.push_back(v(0, ST_FETCH,  8'h00, 0, 0, ST_IDLE,   8'h00, '0));
    vecs.push_back(v(0, 5'b01010,  8'h44, 1, 1, ST_FETCH,  8'h00, MRD | IRL | PCI | BSY));
    vecs.push_back(v(0, ST_IDLE,   8'h00, 1, 1, 5'b01010,  8'h44, BSY));
    vecs.push_back(v(0, ST_FETCH,  8'h00, 0, 0, ST_IDLE,   8'h44, '0));

    drive(1, ST_FETCH, 8'h00, 0, 0);
    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ns, vecs[i].instr, vecs[i].mr, vecs[i].fz);
      #1;
      chk($sformatf("vec%0d", i), {5'd0, state, code, rd, rs, strb},
          {5'd0, vecs[i].st, vecs[i].ir, vecs[i].strb});
    end

`ifdef CPU_CTRL_PERF_CNT_EN
    // 20 LOAD instructions: FETCH -> DECODE -> LOAD, counters saturate.
    @(negedge clk); drive(1, ST_FETCH, 8'h00, 0, 0);
    @(negedge clk); drive(0, ST_FETCH, 8'h00, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); drive(0, ST_DECODE, 8'h01, 1, 0);
      @(negedge clk); drive(0, ST_LOAD,   8'h00, 0, 0);
      @(negedge clk); drive(0, ST_FETCH,  8'h00, 0, 0);
    end
    @(negedge clk); drive(0, ST_IDLE, 8'h00, 0, 0);
    #1;
    chk("instr_cnt_sat", {28'd0, instr_cnt}, 32'hF);
    chk("cycle_cnt_sat", {28'd0, cycle_cnt}, 32'hF);
    @(negedge clk); drive(1, ST_IDLE, 8'h00, 0, 0);
    @(negedge clk); drive(0, ST_IDLE, 8'h00, 0, 0);
    #1;
    chk("cnt_clear", {24'd0, instr_cnt, cycle_cnt}, 32'h0);
`endif

    // Randomized cycles; the first cycle is a reset so the model is in sync.
    m_state = ST_IDLE; m_ir = '0; m_icnt = '0; m_ccnt = '0;
    for (int c = 0; c < 400; c++) begin
      logic        r, mr, fz;
      logic [4:0]  ns;
      logic [13:0] e;
      r  = (c == 0) || ($urandom_range(0, 19) == 0);
      mr = ($urandom_range(0, 2) != 0);
      fz = 1'($urandom);
      case ($urandom_range(0, 9))
        0: ns = 5'($urandom);
        1: ns = ST_IDLE;
        2: ns = ST_DECODE;
        3: ns = ST_LOAD;
        4: ns = ST_MOV;
        5: ns = ST_ALU1;
        6: ns = ST_ALU2;
        7: ns = ST_ALU3;
        8: ns = ST_BRANCH;
        default: ns = ST_FETCH;
      endcase
      @(negedge clk);
      drive(r, ns, 8'($urandom), mr, fz);
      #1;
      e = expect_strb(m_state, m_ir, mr, fz);
      if (c > 0) begin
        chk($sformatf("rnd%0d", c), {5'd0, state, code, rd, rs, strb},
            {5'd0, m_state, m_ir, e});
`ifdef CPU_CTRL_PERF_CNT_EN
        chk($sformatf("rnd_cnt%0d", c), {24'd0, instr_cnt, cycle_cnt},
            {24'd0, m_icnt, m_ccnt});
`endif
      end
      if (r) begin
        m_state = ST_IDLE; m_ir = '0; m_icnt = '0; m_ccnt = '0;
      end else begin
        if (e[6] && m_icnt != '1) m_icnt = m_icnt + 1'b1;
        if (e[5] && m_ccnt != '1) m_ccnt = m_ccnt + 1'b1;
        if (m_state == ST_FETCH && mr) m_ir = instr;
        if (!(m_state == ST_FETCH && !mr)) m_state = ns;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
